// File: rtl/marble_launcher_if.sv
// Board-side bundle of the marble launcher: start/lever/intercept inputs, release pulses and status.
// The slave modport is the launcher's view; master is the board (or bench) view.
interface marble_launcher_if #(
  parameter int CNT_W = 8
);
  logic             i_start;
  logic             i_lever_left;
  logic             i_lever_right;
  logic             i_intercepted;
  logic             o_left;
  logic             o_right;
  logic             o_busy;
  logic             o_done;
  logic             o_stall;
  logic [CNT_W-1:0] o_blue_left;
  logic [CNT_W-1:0] o_red_left;

  modport master (
    output i_start, i_lever_left, i_lever_right, i_intercepted,
    input  o_left, o_right, o_busy, o_done, o_stall, o_blue_left, o_red_left
  );

  modport slave (
    input  i_start, i_lever_left, i_lever_right, i_intercepted,
    output o_left, o_right, o_busy, o_done, o_stall, o_blue_left, o_red_left
  );
endinterface

// File: rtl/marble_launcher.sv
// Marble launcher sequencer: releases blue/red marbles on lever edges until intercept, empty reservoir or flight timeout.
// Release pulse is visible from the edge that samples the event; no backpressure, events outside accepting states are dropped.
module marble_launcher #(
  parameter int NUM_BLUE     = 8,
  parameter int NUM_RED      = 8,
  parameter int PULSE_CYCLES = 2,
  parameter int TIMEOUT      = 64,
  parameter int CNT_W        = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  marble_launcher_if.slave bus
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam int PLS_W = $clog2(PULSE_CYCLES + 1);
  localparam logic [CNT_W-1:0] BLUE_INIT = CNT_W'(NUM_BLUE);
  localparam logic [CNT_W-1:0] RED_INIT  = CNT_W'(NUM_RED);
  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT - 1);
  localparam logic [PLS_W-1:0] PLS_LAST  = PLS_W'(PULSE_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, FIRE_L, FIRE_R, FLIGHT, DONE, STALL} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] blue_q, blue_d;
  logic [CNT_W-1:0] red_q, red_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [PLS_W-1:0] pulse_q, pulse_d;
  logic             start_q, left_q, right_q;
  logic [2:0]       armed_q;
  logic             start_ev, left_ev, right_ev;

  // An input only becomes armed once sampled low, so levels held across reset release stay silent.
  assign start_ev = bus.i_start       & ~start_q & armed_q[0];
  assign left_ev  = bus.i_lever_left  & ~left_q  & armed_q[1];
  assign right_ev = bus.i_lever_right & ~right_q & armed_q[2];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      blue_q  <= BLUE_INIT;
      red_q   <= RED_INIT;
      timer_q <= '0;
      pulse_q <= '0;
      start_q <= 1'b0;
      left_q  <= 1'b0;
      right_q <= 1'b0;
      armed_q <= '0;
    end else begin
      state_q <= state_d;
      blue_q  <= blue_d;
      red_q   <= red_d;
      timer_q <= timer_d;
      pulse_q <= pulse_d;
      start_q <= bus.i_start;
      left_q  <= bus.i_lever_left;
      right_q <= bus.i_lever_right;
      armed_q <= armed_q | ~{bus.i_lever_right, bus.i_lever_left, bus.i_start};
    end
  end

  always_comb begin
    state_d = state_q;
    blue_d  = blue_q;
    red_d   = red_q;
    timer_d = timer_q;
    pulse_d = pulse_q;
    unique case (state_q)
      IDLE, DONE, STALL: begin
        if (start_ev) begin
          red_d   = RED_INIT;
          timer_d = '0;
          pulse_d = '0;
          if (NUM_BLUE > 0) begin
            state_d = FIRE_L;
            blue_d  = BLUE_INIT - CNT_W'(1);
          end else begin
            state_d = DONE;
            blue_d  = BLUE_INIT;
          end
        end
      end
      FIRE_L, FIRE_R: begin
        if (pulse_q == PLS_LAST) begin
          state_d = FLIGHT;
          timer_d = '0;
          pulse_d = '0;
        end else begin
          pulse_d = pulse_q + PLS_W'(1);
        end
      end
      FLIGHT: begin
        timer_d = timer_q + TMR_W'(1);
        // Priority: intercept, then left, then right, then timeout.
        if (bus.i_intercepted) begin
          state_d = DONE;
        end else if (left_ev) begin
          if (blue_q != '0) begin
            state_d = FIRE_L;
            blue_d  = blue_q - CNT_W'(1);
          end else begin
            state_d = DONE;
          end
        end else if (right_ev) begin
          if (red_q != '0) begin
            state_d = FIRE_R;
            red_d   = red_q - CNT_W'(1);
          end else begin
            state_d = DONE;
          end
        end else if (timer_q == TMR_LAST) begin
          state_d = STALL;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.o_left      = (state_q == FIRE_L);
  assign bus.o_right     = (state_q == FIRE_R);
  assign bus.o_busy      = (state_q == FIRE_L) || (state_q == FIRE_R) || (state_q == FLIGHT);
  assign bus.o_done      = (state_q == DONE);
  assign bus.o_stall     = (state_q == STALL);
  assign bus.o_blue_left = blue_q;
  assign bus.o_red_left  = red_q;

endmodule

// File: tb/tb_marble_launcher.sv
// Bench for marble_launcher: event-level reference model feeds a scoreboard, a negedge monitor consumes it.
module tb_marble_launcher;
  localparam int NB = 8, NR = 8, P = 2, TO = 64, W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  marble_launcher_if #(.CNT_W(W)) bus ();
  marble_launcher_if #(.CNT_W(W)) bus1 ();

  marble_launcher #(.NUM_BLUE(NB), .NUM_RED(NR), .PULSE_CYCLES(P), .TIMEOUT(TO), .CNT_W(W))
    dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));
  marble_launcher #(.NUM_BLUE(1), .NUM_RED(NR), .PULSE_CYCLES(P), .TIMEOUT(TO), .CNT_W(W))
    dut1 (.i_clk(clk), .i_rst_n(rst_n), .bus(bus1));

  // kind: 0 left launch, 1 right launch, 2 done, 3 stall
  typedef struct { int kind; int blue; int red; int edge_n; } ev_t;
  ev_t exp_q[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: run phase (0 idle/ended, 1 releasing, 2 in flight) with absolute edge deadlines.
  int m_mode = 0, m_end = 0, m_blue = NB, m_red = NR, m_fire_end = 0, m_fs = 0;
  bit prev_s = 1'b1, prev_l = 1'b1, prev_r = 1'b1;
  bit es, el, er;

  function automatic void m_push(input int kind, input int e);
    ev_t ev;
    ev.kind = kind; ev.blue = m_blue; ev.red = m_red; ev.edge_n = e;
    exp_q.push_back(ev);
  endfunction

  function automatic void m_launch(input int side, input int e);
    if (side == 0) m_blue--; else m_red--;
    m_mode = 1; m_end = 0; m_fire_end = e + P;
    m_push(side, e);
  endfunction

  function automatic void m_finish(input int kind, input int e);
    m_mode = 0; m_end = kind;
    m_push(kind, e);
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_mode = 0; m_end = 0; m_blue = NB; m_red = NR;
      prev_s = 1'b1; prev_l = 1'b1; prev_r = 1'b1;
      exp_q.delete();
    end else begin
      es = bus.i_start && !prev_s;
      el = bus.i_lever_left && !prev_l;
      er = bus.i_lever_right && !prev_r;
      prev_s = bus.i_start; prev_l = bus.i_lever_left; prev_r = bus.i_lever_right;
      case (m_mode)
        0: if (es) begin
             m_blue = NB; m_red = NR;
             if (NB > 0) m_launch(0, cyc); else m_finish(2, cyc);
           end
        1: if (cyc == m_fire_end) begin m_mode = 2; m_fs = cyc; end
        default: begin
          if (bus.i_intercepted) m_finish(2, cyc);
          else if (el) begin if (m_blue > 0) m_launch(0, cyc); else m_finish(2, cyc); end
          else if (er) begin if (m_red > 0) m_launch(1, cyc); else m_finish(2, cyc); end
          else if (cyc - m_fs == TO) m_finish(3, cyc);
        end
      endcase
    end
    cyc++;
  end

  task automatic observe(input int kind);
    ev_t ev;
    if (exp_q.size() == 0) begin
      checks++; failures++;
      $display("FAIL unexpected_event: got kind %0d at edge %0d, expected none", kind, cyc - 1);
    end else begin
      ev = exp_q.pop_front();
      check("event_kind", kind, ev.kind);
      check("event_edge", cyc - 1, ev.edge_n);
      check("event_blue", bus.o_blue_left, ev.blue);
      check("event_red", bus.o_red_left, ev.red);
    end
  endtask

  bit pl, pr, pd, pst;
  int wl, wr;
  always @(negedge clk) begin
    if (!rst_n) begin
      pl = 0; pr = 0; pd = 0; pst = 0; wl = 0; wr = 0;
    end else begin
      if (bus.o_left && !pl) observe(0);
      if (bus.o_right && !pr) observe(1);
      if (bus.o_done && !pd) observe(2);
      if (bus.o_stall && !pst) observe(3);
      if (bus.o_left) wl++; else if (pl) begin check("left_pulse_width", wl, P); wl = 0; end
      if (bus.o_right) wr++; else if (pr) begin check("right_pulse_width", wr, P); wr = 0; end
      check("busy_level", bus.o_busy, m_mode != 0);
      check("done_level", bus.o_done, (m_mode == 0) && (m_end == 2));
      check("stall_level", bus.o_stall, (m_mode == 0) && (m_end == 3));
      check("blue_count", bus.o_blue_left, m_blue);
      check("red_count", bus.o_red_left, m_red);
      pl = bus.o_left; pr = bus.o_right; pd = bus.o_done; pst = bus.o_stall;
    end
  end

  task automatic drive(input bit s, input bit l, input bit r, input bit x, input int n);
    repeat (n) begin
      @(negedge clk); #1;
      bus.i_start = s; bus.i_lever_left = l; bus.i_lever_right = r; bus.i_intercepted = x;
    end
  endtask

  initial begin
    bus.i_start = 0; bus.i_lever_left = 0; bus.i_lever_right = 0; bus.i_intercepted = 0;
    bus1.i_start = 0; bus1.i_lever_left = 0; bus1.i_lever_right = 0; bus1.i_intercepted = 0;
    repeat (3) @(negedge clk);
    check("rst_left", bus.o_left, 0);
    check("rst_right", bus.o_right, 0);
    check("rst_busy", bus.o_busy, 0);
    check("rst_done", bus.o_done, 0);
    check("rst_stall", bus.o_stall, 0);
    check("rst_blue", bus.o_blue_left, NB);
    check("rst_red", bus.o_red_left, NR);
    check("rst_blue_nb1", bus1.o_blue_left, 1);
    #1 rst_n = 1'b1;
    drive(0, 0, 0, 0, 3);

    // start then right lever, end by intercept
    drive(1, 0, 0, 0, 1); drive(0, 0, 0, 0, 3); drive(0, 0, 1, 0, 1);
    drive(0, 0, 0, 0, 4); drive(0, 0, 0, 1, 1); drive(0, 0, 0, 0, 3);
    // intercept beats simultaneous left lever
    drive(1, 0, 0, 0, 1); drive(0, 0, 0, 0, 4); drive(0, 1, 0, 1, 1); drive(0, 0, 0, 0, 3);
    // flight timeout, then restart from STALL
    drive(1, 0, 0, 0, 1); drive(0, 0, 0, 0, 70);
    drive(1, 0, 0, 0, 1); drive(0, 0, 0, 0, 4); drive(0, 0, 0, 1, 1); drive(0, 0, 0, 0, 3);
    // simultaneous edges, then a held lever
    drive(1, 0, 0, 0, 1); drive(0, 0, 0, 0, 4); drive(0, 1, 1, 0, 1); drive(0, 0, 0, 0, 4);
    drive(0, 1, 0, 0, 10); drive(0, 0, 0, 0, 4); drive(0, 0, 0, 1, 1); drive(0, 0, 0, 0, 3);
    // drain the blue reservoir
    drive(1, 0, 0, 0, 1);
    for (int i = 0; i < 8; i++) begin drive(0, 0, 0, 0, 4); drive(0, 1, 0, 0, 1); end
    drive(0, 0, 0, 0, 3);

    // randomized traffic with occasional quiet stretches
    for (int i = 0; i < 2500; i++) begin
      if (i % 500 == 400) drive(0, 0, 0, 0, 70);
      else drive(($urandom % 50) == 0, ($urandom % 5) == 0, ($urandom % 5) == 0,
                 ($urandom % 40) == 0, 1);
    end
    drive(0, 0, 0, 0, 3); drive(0, 0, 0, 1, 1); drive(0, 0, 0, 0, 4);

    // reset during the first pulse cycle, start held across release
    drive(1, 0, 0, 0, 1);
    @(negedge clk); #1 rst_n = 1'b0;
    #1;
    check("midpulse_left", bus.o_left, 0);
    check("midpulse_busy", bus.o_busy, 0);
    check("midpulse_blue", bus.o_blue_left, NB);
    check("midpulse_red", bus.o_red_left, NR);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    drive(1, 0, 0, 0, 5);
    check("held_start_busy", bus.o_busy, 0);
    check("held_start_left", bus.o_left, 0);
    drive(0, 0, 0, 0, 2); drive(1, 0, 0, 0, 1); drive(0, 0, 0, 0, 4);
    drive(0, 0, 0, 1, 1); drive(0, 0, 0, 0, 3);

    // single-blue instance: second left request ends the run
    @(negedge clk); #1 bus1.i_start = 1'b1;
    @(negedge clk);
    check("nb1_left", bus1.o_left, 1);
    check("nb1_blue", bus1.o_blue_left, 0);
    #1 bus1.i_start = 1'b0;
    repeat (3) @(negedge clk);
    #1 bus1.i_lever_left = 1'b1;
    @(negedge clk);
    check("nb1_done", bus1.o_done, 1);
    check("nb1_no_left", bus1.o_left, 0);
    check("nb1_blue_end", bus1.o_blue_left, 0);
    #1 bus1.i_lever_left = 1'b0;

    drive(0, 0, 0, 0, 5);
    check("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
